pmbus_bus_arbiter: RTL and testbench
====================================

# pmbus_bus_arbiter

Shares the slave-side PMBus segment between the external master, which reaches it through the PMBus pass-through, and the CPLD's local polling master. It tracks external bus occupancy from START/STOP pulses and enforces the SMBus bus-free time. It grants the bus to the local master only while the segment is idle, and gates the pass-through off while the local master owns the bus. It also enforces stuck-transaction timeouts on both owners.

## Interface
Parameters:
- T_BUF, 64: sysclk cycles of bus-free time required after any STOP, release or timeout before the local master may be granted.
- EXT_TIMEOUT, 16'hFFFF: maximum sysclk cycles from an external START to its STOP.
- LOC_TIMEOUT, 16'hFFFF: maximum sysclk cycles the local master may hold a grant.

Ports:
- sysclk, in, 1: system clock; one clock domain, all logic on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- ext_start, in, 1: one-cycle pulse from the debounced bus monitor on an external START or repeated START.
- ext_stop, in, 1: one-cycle pulse on an external STOP.
- loc_req, in, 1: level request from the local master.
- loc_done, in, 1: one-cycle pulse; the local master has issued its STOP.
- loc_grant, out, 1: the local master owns the slave segment.
- ext_enable, out, 1: pass-through drivers enabled; low gates the pass-through off from the slave segment.
- arb_state, out, 2: current state; IDLE=0, EXT_ACTIVE=1, BUF_WAIT=2, LOCAL_OWN=3.
- ext_timeout, out, 1: one-cycle pulse when EXT_TIMEOUT expires.
- loc_abort, out, 1: one-cycle pulse when LOC_TIMEOUT expires.
- ext_collision, out, 1: one-cycle pulse when ext_start arrives during LOCAL_OWN.

## Operation
- All outputs are registered.
- Reset values: arb_state=BUF_WAIT, buf_cnt=T_BUF, loc_grant=0, ext_enable=1, all pulse outputs 0, timeout counter 0.
- ext_enable=1 in every state except LOCAL_OWN.
- loc_grant=1 only in LOCAL_OWN.

IDLE:
- ext_start -> EXT_ACTIVE; timeout counter cleared.
- Otherwise loc_req=1 -> LOCAL_OWN; timeout counter cleared.
- ext_start has priority over loc_req in the same cycle.

EXT_ACTIVE:
- ext_start (repeated START) clears the timeout counter and stays in EXT_ACTIVE.
- ext_stop -> BUF_WAIT with buf_cnt=T_BUF.
- Counter reaching EXT_TIMEOUT -> BUF_WAIT with buf_cnt=T_BUF, and pulses ext_timeout.
- ext_stop and ext_start in the same cycle: treat as STOP.

BUF_WAIT:
- buf_cnt decrements each cycle.
- ext_start -> EXT_ACTIVE immediately, at any buf_cnt.
- buf_cnt==0 with no ext_start -> IDLE.
- loc_req is ignored in BUF_WAIT.

LOCAL_OWN:
- loc_done, or loc_req low -> BUF_WAIT with buf_cnt=T_BUF.
- Counter reaching LOC_TIMEOUT -> BUF_WAIT with buf_cnt=T_BUF, and pulses loc_abort.
- ext_start pulses ext_collision and does not change state. The external transaction is not forwarded; the external master sees NACK via pull-up.
- ext_stop is ignored.

Counters and arithmetic:
- Timeout counter is 16-bit and saturates; it never wraps.
- buf_cnt is 16-bit and never underflows; 0 is the terminal value.
- T_BUF=0: BUF_WAIT lasts exactly one cycle.

Reset:
- reset_n low at any point, including mid-LOCAL_OWN, immediately drops loc_grant and forces BUF_WAIT.
- The local master must treat a lost grant as an abort.

## Timing
- loc_req rising in IDLE at edge n -> loc_grant=1 and ext_enable=0 after edge n+1.
- loc_done at edge n -> loc_grant=0 and ext_enable=1 after edge n+1.
- First regrant is no earlier than T_BUF+1 cycles later.
- ext_start/ext_stop response: 1 cycle.
- Pulse outputs assert for exactly one cycle, in the cycle following the event.
- After reset deassertion, the first grant is possible after T_BUF+1 cycles of quiet bus.
- Inputs are synchronous to sysclk. The bus monitor already debounces; no additional synchronisation here.

## Test plan
- Reset, T_BUF=64, loc_req held high -> loc_grant rises 66 cycles after reset_n deasserts; ext_enable falls in the same cycle.
- IDLE, ext_start and loc_req in the same cycle -> arb_state=1, loc_grant stays 0. ext_stop at cycle 100 -> BUF_WAIT; grant 66 cycles after the stop.
- LOCAL_OWN, ext_start pulse -> ext_collision high for 1 cycle, loc_grant stays 1, ext_enable stays 0.
- LOC_TIMEOUT=200, loc_req held, no loc_done -> loc_abort pulse at cycle 200 of ownership, loc_grant=0, BUF_WAIT entered.
- EXT_TIMEOUT=300, ext_start, repeated ext_start at cycle 250, no stop -> ext_timeout at cycle 550 after the first start, then BUF_WAIT.
- reset_n asserted mid-LOCAL_OWN -> loc_grant=0 and ext_enable=1 asynchronously, arb_state=2.

Source files
------------

// File: rtl/pmbus_bus_arbiter.sv
// Arbitrates the slave-side PMBus segment between the external pass-through master
// and the local polling master, with bus-free spacing and stuck-transaction timeouts.
module pmbus_bus_arbiter #(
    parameter int unsigned  T_BUF       = 64,
    parameter logic [15:0]  EXT_TIMEOUT = 16'hFFFF,
    parameter logic [15:0]  LOC_TIMEOUT = 16'hFFFF
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        ext_start,
    input  logic        ext_stop,
    input  logic        loc_req,
    input  logic        loc_done,
    output logic        loc_grant,
    output logic        ext_enable,
    output logic [1:0]  arb_state,
    output logic        ext_timeout,
    output logic        loc_abort,
    output logic        ext_collision
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXT_ACTIVE = 2'd1,
        BUF_WAIT   = 2'd2,
        LOCAL_OWN  = 2'd3
    } state_t;

    localparam logic [15:0] BUF_INIT = 16'(T_BUF);

    state_t      state, state_nx;
    logic [15:0] buf_cnt, buf_nx;
    logic [15:0] tcnt, tcnt_nx, tcnt_inc;
    logic        ext_to_nx, abort_nx, coll_nx;
    logic        ext_hit, loc_hit;

    // Counter saturates at all-ones; hit compares in 17 bits so a limit of 0 is safe.
    assign tcnt_inc = (tcnt == 16'hFFFF) ? tcnt : tcnt + 16'd1;
    assign ext_hit  = ({1'b0, tcnt} + 17'd1) >= {1'b0, EXT_TIMEOUT};
    assign loc_hit  = ({1'b0, tcnt} + 17'd1) >= {1'b0, LOC_TIMEOUT};

    always_comb begin
        state_nx  = state;
        buf_nx    = buf_cnt;
        tcnt_nx   = tcnt_inc;
        ext_to_nx = 1'b0;
        abort_nx  = 1'b0;
        coll_nx   = 1'b0;
        case (state)
            IDLE: begin
                tcnt_nx = 16'd0;
                if (ext_start)
                    state_nx = EXT_ACTIVE;
                else if (loc_req)
                    state_nx = LOCAL_OWN;
            end
            EXT_ACTIVE: begin
                // STOP wins over a coincident START
                if (ext_stop) begin
                    state_nx = BUF_WAIT;
                    buf_nx   = BUF_INIT;
                end else if (ext_start) begin
                    tcnt_nx = 16'd0;
                end else if (ext_hit) begin
                    state_nx  = BUF_WAIT;
                    buf_nx    = BUF_INIT;
                    ext_to_nx = 1'b1;
                end
            end
            BUF_WAIT: begin
                tcnt_nx = 16'd0;
                if (ext_start)
                    state_nx = EXT_ACTIVE;
                else if (buf_cnt == 16'd0)
                    state_nx = IDLE;
                else
                    buf_nx = buf_cnt - 16'd1;
            end
            LOCAL_OWN: begin
                coll_nx = ext_start;
                if (loc_done || !loc_req) begin
                    state_nx = BUF_WAIT;
                    buf_nx   = BUF_INIT;
                end else if (loc_hit) begin
                    state_nx = BUF_WAIT;
                    buf_nx   = BUF_INIT;
                    abort_nx = 1'b1;
                end
            end
            default: begin
                state_nx = BUF_WAIT;
                buf_nx   = BUF_INIT;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BUF_WAIT;
            buf_cnt       <= BUF_INIT;
            tcnt          <= 16'd0;
            loc_grant     <= 1'b0;
            ext_enable    <= 1'b1;
            ext_timeout   <= 1'b0;
            loc_abort     <= 1'b0;
            ext_collision <= 1'b0;
        end else begin
            state         <= state_nx;
            buf_cnt       <= buf_nx;
            tcnt          <= tcnt_nx;
            loc_grant     <= (state_nx == LOCAL_OWN);
            ext_enable    <= (state_nx != LOCAL_OWN);
            ext_timeout   <= ext_to_nx;
            loc_abort     <= abort_nx;
            ext_collision <= coll_nx;
        end
    end

    assign arb_state = state;

endmodule

// File: tb/tb_pmbus_bus_arbiter.sv
// Directed bench for pmbus_bus_arbiter: expected outputs are queued with their
// target cycle and popped on the falling edge of that cycle.
module tb_pmbus_bus_arbiter;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       ext_start, ext_stop, loc_req, loc_done;
    logic       loc_grant, ext_enable, ext_timeout, loc_abort, ext_collision;
    logic [1:0] arb_state;

    pmbus_bus_arbiter #(.T_BUF(64), .EXT_TIMEOUT(16'd300), .LOC_TIMEOUT(16'd200)) dut (
        .sysclk        (sysclk),
        .reset_n       (reset_n),
        .ext_start     (ext_start),
        .ext_stop      (ext_stop),
        .loc_req       (loc_req),
        .loc_done      (loc_done),
        .loc_grant     (loc_grant),
        .ext_enable    (ext_enable),
        .arb_state     (arb_state),
        .ext_timeout   (ext_timeout),
        .loc_abort     (loc_abort),
        .ext_collision (ext_collision)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int         cyc;
        logic [6:0] exp;
        string      tag;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    // {arb_state, loc_grant, ext_enable, ext_timeout, loc_abort, ext_collision}
    wire [6:0] obs = {arb_state, loc_grant, ext_enable, ext_timeout, loc_abort, ext_collision};

    function automatic logic [6:0] mk(input logic [1:0] s, input logic g, input logic e,
                                      input logic [2:0] p);
        return {s, g, e, p};
    endfunction

    task automatic push(input int c, input logic [6:0] exp, input string tag);
        sb_t item;
        item.cyc = c;
        item.exp = exp;
        item.tag = tag;
        sb.push_back(item);
    endtask

    // Checks everything due at the current cycle, then advances one clock.
    task automatic tick();
        sb_t item;
        @(negedge sysclk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            item = sb.pop_front();
            checks++;
            assert (item.cyc == cyc && obs === item.exp)
            else begin
                failures++;
                $error("FAIL %s cyc=%0d due=%0d observed=%b expected=%b",
                       item.tag, cyc, item.cyc, obs, item.exp);
            end
        end
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        reset_n = 1'b0; ext_start = 1'b0; ext_stop = 1'b0; loc_req = 1'b1; loc_done = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        checks++;
        assert (obs === mk(2'd2, 1'b0, 1'b1, 3'b000))
        else begin
            failures++;
            $error("FAIL reset_state observed=%b expected=%b", obs, mk(2'd2, 1'b0, 1'b1, 3'b000));
        end

        // Release reset with loc_req held high: grant after 66 edges
        @(negedge sysclk);
        reset_n = 1'b1;
        cyc = 0;
        push(1,  mk(2'd2, 0, 1, 3'b000), "post_reset_buf");
        push(65, mk(2'd0, 0, 1, 3'b000), "reset_idle");
        push(66, mk(2'd3, 1, 0, 3'b000), "reset_grant");
        @(posedge sysclk);
        #1;
        cyc = 1;
        run_to(66);

        // Collision while the local master owns the bus; STOP ignored
        ext_start = 1'b1;
        push(67, mk(2'd3, 1, 0, 3'b001), "collision_pulse");
        push(68, mk(2'd3, 1, 0, 3'b000), "collision_clear");
        tick(); ext_start = 1'b0;
        tick(); ext_stop = 1'b1;
        push(69, mk(2'd3, 1, 0, 3'b000), "stop_ignored_local");
        tick(); ext_stop = 1'b0;

        // Local timeout at 200 cycles of ownership, then regrant
        push(265, mk(2'd3, 1, 0, 3'b000), "loc_before_abort");
        push(266, mk(2'd2, 0, 1, 3'b010), "loc_abort_pulse");
        push(267, mk(2'd2, 0, 1, 3'b000), "loc_abort_clear");
        push(331, mk(2'd0, 0, 1, 3'b000), "abort_idle");
        push(332, mk(2'd3, 1, 0, 3'b000), "abort_regrant");
        run_to(340);

        // loc_done release then loc_req drop
        loc_done = 1'b1;
        push(341, mk(2'd2, 0, 1, 3'b000), "done_release");
        push(406, mk(2'd0, 0, 1, 3'b000), "done_idle");
        push(407, mk(2'd3, 1, 0, 3'b000), "done_regrant");
        tick(); loc_done = 1'b0;
        run_to(410);
        loc_req = 1'b0;
        push(411, mk(2'd2, 0, 1, 3'b000), "req_drop_release");
        push(476, mk(2'd0, 0, 1, 3'b000), "req_drop_idle");
        run_to(480);

        // ext_start beats loc_req; STOP 100 cycles later; grant 66 after STOP
        ext_start = 1'b1; loc_req = 1'b1;
        push(481, mk(2'd1, 0, 1, 3'b000), "start_priority");
        tick(); ext_start = 1'b0;
        run_to(580);
        ext_stop = 1'b1;
        push(580, mk(2'd1, 0, 1, 3'b000), "ext_active_hold");
        push(581, mk(2'd2, 0, 1, 3'b000), "ext_stop_buf");
        push(646, mk(2'd0, 0, 1, 3'b000), "stop_idle");
        push(647, mk(2'd3, 1, 0, 3'b000), "stop_grant");
        tick(); ext_stop = 1'b0;
        run_to(650);
        loc_req = 1'b0;
        push(716, mk(2'd0, 0, 1, 3'b000), "idle_before_ext");
        run_to(720);

        // External timeout restarted by a repeated START
        ext_start = 1'b1;
        push(721, mk(2'd1, 0, 1, 3'b000), "ext_start2");
        tick(); ext_start = 1'b0;
        run_to(970);
        ext_start = 1'b1;
        push(971, mk(2'd1, 0, 1, 3'b000), "rep_start");
        push(1270, mk(2'd1, 0, 1, 3'b000), "ext_before_timeout");
        push(1271, mk(2'd2, 0, 1, 3'b100), "ext_timeout_pulse");
        push(1272, mk(2'd2, 0, 1, 3'b000), "ext_timeout_clear");
        tick(); ext_start = 1'b0;
        run_to(1280);

        // START during BUF_WAIT, then coincident START+STOP treated as STOP
        ext_start = 1'b1;
        push(1281, mk(2'd1, 0, 1, 3'b000), "buf_start");
        tick(); ext_start = 1'b0;
        run_to(1290);
        ext_start = 1'b1; ext_stop = 1'b1;
        push(1291, mk(2'd2, 0, 1, 3'b000), "start_stop_as_stop");
        tick(); ext_start = 1'b0; ext_stop = 1'b0;
        tick(); loc_req = 1'b1;
        push(1300, mk(2'd2, 0, 1, 3'b000), "req_ignored_buf");
        push(1356, mk(2'd0, 0, 1, 3'b000), "final_idle");
        push(1357, mk(2'd3, 1, 0, 3'b000), "final_grant");
        run_to(1360);

        // Asynchronous reset mid-ownership
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        assert (obs === mk(2'd2, 1'b0, 1'b1, 3'b000))
        else begin
            failures++;
            $error("FAIL async_reset observed=%b expected=%b", obs, mk(2'd2, 1'b0, 1'b1, 3'b000));
        end
        tick();
        reset_n = 1'b1;
        tick();

        checks++;
        assert (sb.size() == 0)
        else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
